current_sense_sequencer: RTL and testbench

Autonomous readout controller for the TLI4970 motor-current sensor on the motor board. It schedules periodic (or on-demand) 16-bit SPI read transactions and generates CS/SCK itself. It decodes each received frame into a signed current sample or a sensor status word and flags link and parity faults. It replaces the ad-hoc delay counter plus SPI master pairing in the top level and feeds `current` to the comms block.

---
 rtl/current_sense_pkg.sv | 44 ++++
 rtl/spi_frame_rx.sv | 63 ++++++
 rtl/current_sense_sequencer.sv | 143 ++++++++++++++
 tb/tb_current_sense_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/current_sense_pkg.sv
// Shared definitions for the TLI4970 current-sense readout: FSM states,
// frame layout and the frame classification/decode helpers.
package current_sense_pkg;

  localparam int FRAME_BITS     = 16;
  localparam int STATUS_BIT     = 15;
  localparam int PARITY_BIT     = 14;
  localparam int OCD_BIT        = 13;
  localparam int DATA_MSB       = 12;
  localparam int DATA_LSB       = 0;
  localparam int CURRENT_OFFSET = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_PARSE,
    ST_GAP
  } state_t;

  typedef enum logic [1:0] {
    DEC_LINK,
    DEC_PARITY,
    DEC_STATUS,
    DEC_CURRENT
  } decode_t;

  // Priority: stuck line, then parity, then frame type.
  function automatic decode_t classify(input logic [FRAME_BITS-1:0] f);
    if (f == '0 || f == '1) return DEC_LINK;
    if (^f) return DEC_PARITY;
    if (f[STATUS_BIT]) return DEC_STATUS;
    return DEC_CURRENT;
  endfunction

  // Raw 13-bit code minus the offset; modulo 2^13 this only flips the MSB.
  function automatic logic [DATA_MSB:0] frame_to_current(input logic [FRAME_BITS-1:0] f);
    logic [DATA_MSB:0] raw;
    raw = f[DATA_MSB:DATA_LSB];
    return raw - (DATA_MSB+1)'(CURRENT_OFFSET);
  endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// SPI receive engine: SCK divider, MISO synchronizer, 16-bit MSB-first shift.
// start (1 cycle) launches a frame; done marks the cycle whose closing edge captures the last bit.
module spi_frame_rx
  import current_sense_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  miso,
  output logic                  sck,
  output logic                  done,
  output logic [FRAME_BITS-1:0] frame
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [1:0]            sync;
  logic                  running;
  logic [DIV_W-1:0]      div_cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shift_q;
  logic                  half_end;

  assign half_end = running && (div_cnt == DIV_LAST);
  assign done     = half_end && sck && (bit_cnt == 4'd15);
  assign frame    = shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      running <= 1'b0;
      sck     <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
    end else begin
      sync <= {sync[0], miso};
      if (start) begin
        // First rising SCK edge coincides with the end of the CS setup phase.
        running <= 1'b1;
        sck     <= 1'b1;
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (running) begin
        if (half_end) begin
          div_cnt <= '0;
          sck     <= ~sck;
          if (sck) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], sync[1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) running <= 1'b0;
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/current_sense_sequencer.sv
// TLI4970 readout controller: request scheduling, CS phase sequencing and
// decode of each received frame into current/status/fault outputs.
module current_sense_sequencer
  import current_sense_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int PERIOD  = 64000
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          trigger,
  input  logic          cs_miso,
  output logic          cs_n,
  output logic          cs_clk,
  output logic [12:0]   current,
  output logic          current_valid,
  output logic          ocd,
  output logic [14:0]   status_word,
  output logic          status_valid,
  output logic          parity_err,
  output logic          link_err,
  output logic          overrun,
  output logic          busy
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CLK_DIV - 2);
  localparam int PER_W = $clog2(PERIOD);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic [PER_W-1:0]      per_cnt;
  logic                  pending;
  logic                  wrap;
  logic                  req;
  logic                  accept;
  logic                  rx_start;
  logic                  rx_done;
  logic [FRAME_BITS-1:0] rx_frame;

  assign wrap   = enable && (per_cnt == PER_LAST);
  assign req    = wrap || trigger;
  assign accept = (state == ST_IDLE) && pending;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt <= '0;
    end else if (!enable || wrap) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + PER_W'(1);
    end
  end

  // A request landing on an already pending one is merged and flagged.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      pending <= req || (pending && !accept);
      overrun <= req && pending && !accept;
    end
  end

  always_comb begin
    state_next = state;
    rx_start   = 1'b0;
    case (state)
      ST_IDLE:  if (pending) state_next = ST_SETUP;
      ST_SETUP: if (cnt == PHASE_LAST) begin
        rx_start   = 1'b1;
        state_next = ST_SHIFT;
      end
      ST_SHIFT: if (rx_done) state_next = ST_HOLD;
      ST_HOLD:  if (cnt == PHASE_LAST) state_next = ST_PARSE;
      ST_PARSE: state_next = ST_GAP;
      ST_GAP:   if (cnt == GAP_LAST) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // cnt times the phase currently occupied; it restarts on every transition.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      cs_n  <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= (state_next != state) ? '0 : cnt + CNT_W'(1);
      cs_n  <= !(state_next inside {ST_SETUP, ST_SHIFT, ST_HOLD});
      busy  <= (state_next != ST_IDLE);
    end
  end

  spi_frame_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk   (CLK),
    .rst_n (reset_n),
    .start (rx_start),
    .miso  (cs_miso),
    .sck   (cs_clk),
    .done  (rx_done),
    .frame (rx_frame)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      current       <= '0;
      ocd           <= 1'b0;
      status_word   <= '0;
      current_valid <= 1'b0;
      status_valid  <= 1'b0;
      parity_err    <= 1'b0;
      link_err      <= 1'b0;
    end else begin
      current_valid <= 1'b0;
      status_valid  <= 1'b0;
      parity_err    <= 1'b0;
      link_err      <= 1'b0;
      if (state == ST_PARSE) begin
        case (classify(rx_frame))
          DEC_LINK:   link_err <= 1'b1;
          DEC_PARITY: parity_err <= 1'b1;
          DEC_STATUS: begin
            status_word  <= rx_frame[STATUS_BIT-1:0];
            status_valid <= 1'b1;
          end
          default: begin
            current       <= frame_to_current(rx_frame);
            ocd           <= rx_frame[OCD_BIT];
            current_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_current_sense_sequencer.sv
// Directed and randomized bench for current_sense_sequencer with a behavioural
// sensor model on the SPI pins and an arithmetic decode reference.
module tb_current_sense_sequencer;

  localparam int CLK_DIV = 16;
  localparam int PERIOD  = 2000;
  localparam int LAT     = 33 * CLK_DIV + 1;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        trigger = 1'b0;
  logic        cs_miso = 1'b0;
  logic        cs_n, cs_clk;
  logic [12:0] current;
  logic        current_valid, ocd, status_valid, parity_err, link_err, overrun, busy;
  logic [14:0] status_word;

  current_sense_sequencer #(.CLK_DIV(CLK_DIV), .PERIOD(PERIOD)) dut (
    .CLK           (CLK),
    .reset_n       (reset_n),
    .enable        (enable),
    .trigger       (trigger),
    .cs_miso       (cs_miso),
    .cs_n          (cs_n),
    .cs_clk        (cs_clk),
    .current       (current),
    .current_valid (current_valid),
    .ocd           (ocd),
    .status_word   (status_word),
    .status_valid  (status_valid),
    .parity_err    (parity_err),
    .link_err      (link_err),
    .overrun       (overrun),
    .busy          (busy)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int cyc = 0;
  int sck_rises = 0;
  int dec_cnt = 0;
  int cs_falls = 0;
  logic [3:0] pulse_vec;
  assign pulse_vec = {link_err, parity_err, status_valid, current_valid};

  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge cs_clk) sck_rises <= sck_rises + 1;
  always @(negedge cs_n) cs_falls <= cs_falls + 1;
  always @(posedge CLK) if (pulse_vec != 4'b0) dec_cnt <= dec_cnt + 1;

  // Sensor: presents MSB at CS fall, next bit after each SCK fall.
  logic [15:0] tx_frame = 16'h0;
  logic [15:0] sh = 16'h0;
  int          bit_idx = 0;
  logic        cs_n_prev = 1'b1;
  logic        sck_prev = 1'b0;

  always @(posedge CLK) begin
    #1;
    if (cs_n_prev && !cs_n) begin
      sh      <= tx_frame;
      bit_idx <= 15;
      cs_miso <= tx_frame[15];
    end else if (!cs_n && sck_prev && !cs_clk && bit_idx > 0) begin
      bit_idx <= bit_idx - 1;
      cs_miso <= sh[bit_idx-1];
    end
    cs_n_prev <= cs_n;
    sck_prev  <= cs_clk;
  end

  // scoreboard / reference model
  int          tests = 0;
  int          fails = 0;
  logic [12:0] exp_current = '0;
  logic        exp_ocd = 1'b0;
  logic [14:0] exp_status = '0;
  logic [3:0]  exp_vec = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [15:0] f);
    int v;
    if (f == 16'h0000 || f == 16'hFFFF) exp_vec = 4'b1000;
    else if ($countones(f) % 2 == 1) exp_vec = 4'b0100;
    else if (f[15]) begin
      exp_vec    = 4'b0010;
      exp_status = f[14:0];
    end else begin
      exp_vec     = 4'b0001;
      v           = int'(f[12:0]) - 4096;
      exp_current = v[12:0];
      exp_ocd     = f[13];
    end
  endtask

  // drivers
  task automatic pulse_trigger();
    @(negedge CLK);
    trigger = 1'b1;
    @(negedge CLK);
    trigger = 1'b0;
  endtask

  task automatic wait_cs_fall(input int budget, output int t);
    int n = 0;
    while (cs_n !== 1'b0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    t = cyc;
    check("cs_fall_seen", cs_n, 0);
  endtask

  task automatic wait_decode(input int t0, input logic [15:0] f);
    int n = 0;
    model(f);
    while (pulse_vec === 4'b0 && n < 700) begin
      @(negedge CLK);
      n++;
    end
    check("decode_latency", cyc - t0, LAT);
    check("decode_pulses", pulse_vec, exp_vec);
    check("current", current, exp_current);
    check("ocd", ocd, exp_ocd);
    check("status_word", status_word, exp_status);
    @(negedge CLK);
    check("pulse_width", pulse_vec, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 700) begin
      @(negedge CLK);
      n++;
    end
    check("busy_drops", busy, 0);
  endtask

  task automatic do_read(input logic [15:0] f);
    int t0;
    tx_frame = f;
    pulse_trigger();
    wait_cs_fall(4, t0);
    wait_decode(t0, f);
    wait_idle();
  endtask

  logic [15:0] rf;
  int t0, t1, ta, tb, tc, ten, r0, snap_dec, snap_cs;

  initial begin
    // reset values
    repeat (3) @(negedge CLK);
    check("rst_cs_n", cs_n, 1);
    check("rst_cs_clk", cs_clk, 0);
    check("rst_current", current, 0);
    check("rst_ocd", ocd, 0);
    check("rst_status", status_word, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {overrun, pulse_vec}, 0);
    reset_n = 1'b1;
    repeat (50) @(negedge CLK);
    check("no_request_after_reset", cs_n, 1);

    // first frame with edge timing
    r0 = sck_rises;
    tx_frame = 16'h1064;
    pulse_trigger();
    wait_cs_fall(4, t0);
    check("busy_with_cs", busy, 1);
    while (cyc < t0 + 33 * CLK_DIV - 1) @(negedge CLK);
    check("cs_low_in_hold", cs_n, 0);
    check("sck_low_in_hold", cs_clk, 0);
    @(negedge CLK);
    check("cs_rise_time", cs_n, 1);
    check("sck_rise_count", sck_rises - r0, 16);
    wait_decode(t0, 16'h1064);
    check("current_100", current, 13'd100);
    wait_idle();

    // directed frames
    do_read(16'h0F9C);
    check("current_m100", current, 13'h1F9C);
    do_read(16'h7064);
    check("ocd_set", ocd, 1);
    do_read(16'hC003);
    check("status_4003", status_word, 15'h4003);
    do_read(16'h5064);
    do_read(16'hFFFF);
    do_read(16'h0000);

    // randomized frames, mostly with even parity
    for (int i = 0; i < 12; i++) begin
      rf = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) != 0 && ($countones(rf) % 2 == 1)) rf[14] = ~rf[14];
      do_read(rf);
    end

    // periodic triggering
    tx_frame = 16'h0F9C;
    @(negedge CLK);
    enable = 1'b1;
    ten = cyc;
    wait_cs_fall(PERIOD + 10, ta);
    check("first_period_start", ta - ten, PERIOD + 1);
    wait_idle();
    wait_cs_fall(PERIOD + 10, tb);
    check("period_ab", tb - ta, PERIOD);
    wait_idle();
    wait_cs_fall(PERIOD + 10, tc);
    check("period_bc", tc - tb, PERIOD);
    enable = 1'b0;
    wait_decode(tc, 16'h0F9C);
    wait_idle();
    snap_cs = cs_falls;
    repeat (PERIOD + 50) @(negedge CLK);
    check("disabled_no_cs", cs_falls - snap_cs, 0);

    // request during busy, then overrun
    tx_frame = 16'h1064;
    pulse_trigger();
    wait_cs_fall(4, t0);
    tx_frame = 16'h7064;
    repeat (100) @(negedge CLK);
    pulse_trigger();
    check("no_overrun_first", overrun, 0);
    repeat (10) @(negedge CLK);
    pulse_trigger();
    check("overrun_pulse", overrun, 1);
    @(negedge CLK);
    check("overrun_width", overrun, 0);
    wait_decode(t0, 16'h1064);
    while (busy !== 1'b0 && cyc < t0 + 700) @(negedge CLK);
    tb = cyc;
    wait_cs_fall(4, t1);
    check("restart_after_gap", t1 - tb, 1);
    wait_decode(t1, 16'h7064);
    wait_idle();

    // reset mid-frame at SCK edge 8
    tx_frame = 16'h0F9C;
    pulse_trigger();
    wait_cs_fall(4, t0);
    while (cyc < t0 + 15 * CLK_DIV) @(negedge CLK);
    check("sck_edge8_high", cs_clk, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_cs_n", cs_n, 1);
    check("mid_rst_cs_clk", cs_clk, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_current", current, 0);
    exp_current = '0;
    exp_ocd     = 1'b0;
    exp_status  = '0;
    snap_dec = dec_cnt;
    repeat (2) @(negedge CLK);
    reset_n = 1'b1;
    repeat (600) @(negedge CLK);
    check("no_decode_after_rst", dec_cnt - snap_dec, 0);
    check("idle_after_rst", cs_n, 1);
    do_read(16'h1064);
    check("current_after_rst", current, 13'd100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
